// File: rtl/ram_stream_reader.sv
// ram_stream_reader: issues read bursts to a synchronous RAM and streams the words out through a credit-guarded FIFO
module ram_stream_reader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t                state_q, state_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
   logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d, recv_left_q, recv_left_d;
   logic [RD_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         fifo_count_q, fifo_count_d, in_flight;
   logic                  issue, push, pop;
   assign busy        = busy_q;
   assign done        = done_q;
   assign ram_address = issue ? addr_q : last_addr_q;
   assign ram_wren    = 1'b0;
   assign out_data    = mem_q[rd_ptr_q];
   assign out_valid   = fifo_count_q != '0;
   // a read issues only while FIFO slots not yet claimed by stored or in-flight words remain
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + CW'(vld_q[i]);
      issue = state_q == ISSUE && issue_left_q != '0 && SW'(fifo_count_q) + SW'(in_flight) < SW'(FIFO_DEPTH);
      push = vld_q[RD_LATENCY-1];
      pop = out_valid && out_ready;
      vld_d = RD_LATENCY'({vld_q, issue});
      addr_d = issue ? addr_q + 1'b1 : addr_q;
      last_addr_d = issue ? addr_q : last_addr_q;
      issue_left_d = issue ? issue_left_q - 1'b1 : issue_left_q;
      recv_left_d = push ? recv_left_q - 1'b1 : recv_left_q;
      state_d = state_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (state_q == IDLE && start) begin
         done_d = count == '0;
         if (count != '0) begin
            state_d = ISSUE;
            busy_d = 1'b1;
            addr_d = base_addr;
            issue_left_d = count;
            recv_left_d = count;
         end
      end
      if (state_q == ISSUE && issue_left_d == '0) state_d = DRAIN;
      if (state_q == DRAIN && recv_left_q == '0 && fifo_count_q == '0) begin
         state_d = IDLE;
         busy_d = 1'b0;
         done_d = 1'b1;
      end
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = ram_q;
      wr_ptr_d = push ? (wr_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
   end
   // all state registers; reset also drops every in-flight read marker
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         addr_q       <= '0;
         last_addr_q  <= '0;
         issue_left_q <= '0;
         recv_left_q  <= '0;
         vld_q        <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         addr_q       <= addr_d;
         last_addr_q  <= last_addr_d;
         issue_left_q <= issue_left_d;
         recv_left_q  <= recv_left_d;
         vld_q        <= vld_d;
         mem_q        <= mem_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         fifo_count_q <= fifo_count_d;
      end
   end
   a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
      !(push && !pop && fifo_count_q == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bursts against a RAM model, with a queue scoreboard checked by a stream monitor
module tb_ram_stream_reader;
   localparam int AW = 5;
   localparam int DW = 8;
   localparam int LAT = 1;
   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   count = '0;
   logic          busy, done, ram_wren, out_valid;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_q, out_data;
   logic [DW-1:0] ram [32];
   logic [DW-1:0] sb [$];
   logic [DW-1:0] held = '0;
   logic          stall_q = 1'b0;
   int            total = 0, bad = 0, done_cnt = 0, delivered = 0;
   ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .FIFO_DEPTH(4)) dut (
      .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .ram_address(ram_address), .ram_wren(ram_wren), .ram_q(ram_q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));
   // free-running clock
   always #5 clock = ~clock;
   // single-cycle-latency synchronous RAM model
   always @(posedge clock) ram_q <= ram[ram_address];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic expect_words(input int b, input int n);
      for (int i = 0; i < n; i++) sb.push_back(DW'(((b + i) % 32) * 3));
   endtask
   task automatic go(input int b, input int n);
      @(posedge clock); #1;
      base_addr = AW'(b);
      count = (AW + 1)'(n);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask
   task automatic wait_done(input string name, input int d0);
      int k = 0;
      while (done_cnt == d0 && k < 400) begin
         @(posedge clock); #1;
         k++;
      end
      repeat (3) @(posedge clock);
      #1;
      chk(name, done_cnt - d0, 1);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_sb_empty"}, sb.size(), 0);
   endtask
   // stream monitor: scoreboard pops, stall stability, done/busy and write-enable checks
   always @(negedge clock) begin
      if (!resetn) stall_q = 1'b0;
      else begin
         chk("ram_wren", ram_wren, 1'b0);
         if (stall_q) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, held);
         end
         if (done) begin
            done_cnt++;
            chk("done_busy", busy, 1'b0);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
            else chk("data", out_data, sb.pop_front());
            delivered++;
         end
         stall_q = out_valid && !out_ready;
         held = out_data;
      end
   end
   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   // directed stimulus
   initial begin
      int k, d0, n0;
      for (int i = 0; i < 32; i++) ram[i] = DW'(i * 3);
      repeat (2) @(negedge clock);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_addr", ram_address, 5'd0);
      chk("rst_data", out_data, 8'h00);
      @(posedge clock); #1;
      resetn = 1'b1;
      out_ready = 1'b1;
      // base 4, count 3, latency check
      expect_words(4, 3);
      d0 = done_cnt;
      go(4, 3);
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!out_valid && k < 20);
      chk("t1_latency", k, LAT + 2);
      chk("t1_first", out_data, 8'h0C);
      wait_done("t1_done", d0);
      // wrap-around addresses 30,31,0,1
      expect_words(30, 4);
      d0 = done_cnt;
      go(30, 4);
      @(negedge clock); chk("t2_addr0", ram_address, 5'd30);
      @(negedge clock); chk("t2_addr1", ram_address, 5'd31);
      @(negedge clock); chk("t2_addr2", ram_address, 5'd0);
      @(negedge clock); chk("t2_addr3", ram_address, 5'd1);
      @(negedge clock); chk("t2_addr_hold", ram_address, 5'd1);
      wait_done("t2_done", d0);
      // full 32-word burst, ready pattern 1,0,0,1, ignored mid-burst start
      expect_words(0, 32);
      d0 = done_cnt;
      n0 = delivered;
      go(0, 32);
      for (int i = 0; i < 400 && done_cnt == d0; i++) begin
         @(posedge clock); #1;
         out_ready = (i % 4 == 0) || (i % 4 == 3);
         base_addr = AW'(7);
         count = (AW + 1)'(5);
         start = i == 10;
      end
      start = 1'b0;
      out_ready = 1'b1;
      wait_done("t3_done", d0);
      chk("t3_count", delivered - n0, 32);
      // consumer stalled: only 4 reads issue
      expect_words(8, 8);
      d0 = done_cnt;
      out_ready = 1'b0;
      go(8, 8);
      repeat (20) @(negedge clock);
      chk("t4_addr_stop", ram_address, 5'd11);
      chk("t4_valid", out_valid, 1'b1);
      chk("t4_head", out_data, 8'h18);
      chk("t4_busy", busy, 1'b1);
      chk("t4_no_done", done_cnt - d0, 0);
      @(posedge clock); #1;
      out_ready = 1'b1;
      wait_done("t4_done", d0);
      // zero-length burst
      go(3, 0);
      @(negedge clock);
      chk("t5_done", done, 1'b1);
      chk("t5_busy", busy, 1'b0);
      chk("t5_addr", ram_address, 5'd15);
      @(negedge clock);
      chk("t5_done_low", done, 1'b0);
      chk("t5_busy_low", busy, 1'b0);
      chk("t5_valid", out_valid, 1'b0);
      // reset after 2 of 6 words, then a fresh burst
      expect_words(20, 6);
      d0 = done_cnt;
      n0 = delivered;
      go(20, 6);
      k = 0;
      while (delivered < n0 + 2 && k < 100) begin
         @(posedge clock); #1;
         k++;
      end
      chk("t6_two_words", delivered - n0, 2);
      resetn = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_addr", ram_address, 5'd0);
      chk("t6_rst_data", out_data, 8'h00);
      chk("t6_rst_done", done, 1'b0);
      sb.delete();
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      repeat (5) @(negedge clock);
      chk("t6_late_valid", out_valid, 1'b0);
      chk("t6_no_done", done_cnt - d0, 0);
      expect_words(2, 5);
      d0 = done_cnt;
      go(2, 5);
      wait_done("t6_done", d0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
